case_9_sdiv_15s_7s_8_seq: RTL

- Sequential signed divider, the inverse of the 8s x 7s -> 15 multiplier in the same HLS datapath.
- Takes a 15-bit signed dividend and a 7-bit signed divisor, and returns a truncating quotient and remainder.
- Radix-2 restoring algorithm, one bit per cycle.
- Uses a valid/ready handshake on both sides. One operation in flight at a time.

---
 rtl/case_9_sdiv_pkg.sv | 32 +++
 rtl/case_9_sdiv_step.sv | 31 +++
 rtl/case_9_sdiv_15s_7s_8_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/case_9_sdiv_pkg.sv
// Shared types and constants for the 15s / 7s sequential signed divider.
// States, default widths and the special-case result constants live here.
package case_9_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } sdiv_state_t;

  localparam int DIN0_W    = 15;
  localparam int DIN1_W    = 7;
  localparam int DOUT_W    = 15;
  localparam int CNT_W     = 4;
  localparam int ITER_LAST = DIN0_W - 1;

  localparam logic [DIN0_W-1:0] MOST_NEG_DIN0 = {1'b1, {(DIN0_W-1){1'b0}}};
  localparam logic [DOUT_W-1:0] QUOT_ALL_ONES = {DOUT_W{1'b1}};
  localparam logic [DIN1_W-1:0] DIVISOR_NEG1  = {DIN1_W{1'b1}};

  // Two's-complement magnitude; the most-negative value maps onto its own
  // bit pattern, which reads correctly as an unsigned magnitude.
  function automatic logic [DIN0_W-1:0] abs_dividend(input logic [DIN0_W-1:0] v);
    return v[DIN0_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DIN1_W-1:0] abs_divisor(input logic [DIN1_W-1:0] v);
    return v[DIN1_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/case_9_sdiv_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit,
// subtract the divisor magnitude when it fits, and emit the quotient bit.
module case_9_sdiv_step
  import case_9_sdiv_pkg::*;
#(
  parameter int DIVW = DIN1_W
) (
  input  logic [DIVW:0]   partial,
  input  logic            dvd_bit,
  input  logic [DIVW-1:0] divisor,
  output logic [DIVW:0]   partial_next,
  output logic            q_bit
);

  logic [DIVW:0] shifted;
  logic          fits;

  assign shifted = {partial[DIVW-1:0], dvd_bit};

  // A set guard bit already exceeds any divisor magnitude; it stays clear
  // in normal operation because the remainder is always below the divisor.
  always_comb begin
    fits         = partial[DIVW] || (shifted >= {1'b0, divisor});
    q_bit        = fits;
    partial_next = shifted;
    if (fits) begin
      partial_next = shifted - {1'b0, divisor};
    end
  end

endmodule

// File: rtl/case_9_sdiv_15s_7s_8_seq.sv
// Sequential signed divider (15s / 7s), restoring radix-2, one bit per cycle,
// with valid/ready handshakes and C-style truncating quotient/remainder.
module case_9_sdiv_15s_7s_8_seq
  import case_9_sdiv_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned ITER_MAX = din0_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_START = CNT_WIDTH'(ITER_MAX);

  if (dout_WIDTH != din0_WIDTH) begin : g_bad_dout
    $error("dout_WIDTH must equal din0_WIDTH");
  end
  if ($clog2(din0_WIDTH) > CNT_WIDTH) begin : g_bad_cnt
    $error("CNT_WIDTH too small for din0_WIDTH iterations");
  end

  sdiv_state_t           state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [din0_WIDTH-1:0] work;
  logic [din1_WIDTH-1:0] div_mag;
  logic [din1_WIDTH:0]   partial;
  logic                  sign_dvd;
  logic                  sign_dvs;
  logic                  zero_flag;
  logic                  ovf_flag;

  logic [din1_WIDTH:0]   partial_next;
  logic                  q_bit;

  // The dividend register doubles as the quotient: its MSB feeds the step
  // and each new quotient bit enters at the LSB.
  case_9_sdiv_step #(
    .DIVW(din1_WIDTH)
  ) u_step (
    .partial      (partial),
    .dvd_bit      (work[din0_WIDTH-1]),
    .divisor      (div_mag),
    .partial_next (partial_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      work        <= '0;
      div_mag     <= '0;
      partial     <= '0;
      sign_dvd    <= 1'b0;
      sign_dvs    <= 1'b0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= abs_dividend(din0);
            div_mag   <= abs_divisor(din1);
            sign_dvd  <= din0[din0_WIDTH-1];
            sign_dvs  <= din1[din1_WIDTH-1];
            zero_flag <= (din1 == '0);
            ovf_flag  <= (din0 == MOST_NEG_DIN0) && (din1 == DIVISOR_NEG1);
            partial   <= '0;
            cnt       <= CNT_START;
            in_ready  <= 1'b0;
            state     <= CALC;
          end
        end

        CALC: begin
          work    <= {work[din0_WIDTH-2:0], q_bit};
          partial <= partial_next;
          if (cnt == '0) begin
            state <= FIXUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // Special cases still spend the full iteration time so latency is fixed.
        FIXUP: begin
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          if (zero_flag) begin
            quot        <= QUOT_ALL_ONES;
            rem         <= '0;
            div_by_zero <= 1'b1;
          end else if (ovf_flag) begin
            quot     <= MOST_NEG_DIN0;
            rem      <= '0;
            overflow <= 1'b1;
          end else begin
            quot <= (sign_dvd ^ sign_dvs) ? (~work + 1'b1) : work;
            rem  <= sign_dvd ? (~partial[din1_WIDTH-1:0] + 1'b1)
                             : partial[din1_WIDTH-1:0];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
